// File: rtl/weight_bias_loader.sv
// weight_bias_loader: routes bias/weight words from the AXI weight reader into the bias
// buffer and a ping-pong weight buffer. Define WBL_ERR_CHECK_EN to enable the sticky O_err flag.
module weight_bias_loader #(
    parameter int unsigned C_DATA_WIDTH = 128,
    parameter int unsigned C_BIAS_AW    = 8,
    parameter int unsigned C_WGT_AW     = 10
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_ap_start,
    input  logic [31:0]             I_in_datab_bytes,
    input  logic [31:0]             I_in_dataw_bytes,
    input  logic [C_DATA_WIDTH-1:0] I_mem_din,
    input  logic                    I_mem_din_valid,
    input  logic                    I_weight_ch,
    output logic                    O_bias_we,
    output logic [C_BIAS_AW-1:0]    O_bias_waddr,
    output logic [C_DATA_WIDTH-1:0] O_bias_wdata,
    output logic                    O_wgt_we,
    output logic                    O_wgt_bank,
    output logic [C_WGT_AW-1:0]     O_wgt_waddr,
    output logic [C_DATA_WIDTH-1:0] O_wgt_wdata,
    input  logic [1:0]              I_bank_release,
    output logic [1:0]              O_bank_valid,
    output logic                    O_load_ready,
    output logic                    O_ap_done,
    output logic                    O_err
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             start_q;
    logic             bank_ptr_q;
    logic             active_q;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] nw_q;
    logic [CNT_W-1:0] bias_cnt_q;
    logic [CNT_W-1:0] wgt_cnt_q;

    logic             start_edge_c;
    logic             accept_c;
    logic             load_full_c;
    logic             bias_hit_c;
    logic             wgt_hit_c;
    logic [1:0]       bank_valid_d;

    // Byte count rounded up to whole 16-byte words.
    function automatic logic [CNT_W-1:0] words_of(input logic [CNT_W-1:0] bytes);
        return (bytes >> 4) + CNT_W'(|bytes[3:0]);
    endfunction

    assign O_load_ready = (state_q == ST_IDLE) && !O_bank_valid[bank_ptr_q];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_LOAD;
            ST_LOAD: if (load_full_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_edge_c = I_ap_start && !start_q;
        accept_c     = start_edge_c && O_load_ready;
        load_full_c  = (bias_cnt_q >= nb_q) && (wgt_cnt_q >= nw_q);
        bias_hit_c   = (state_q == ST_LOAD) && I_mem_din_valid && !I_weight_ch
                       && (bias_cnt_q < nb_q);
        wgt_hit_c    = (state_q == ST_LOAD) && I_mem_din_valid && I_weight_ch
                       && (wgt_cnt_q < nw_q);
        // A completing bank wins over a same-cycle release of that bank.
        bank_valid_d = O_bank_valid & ~I_bank_release;
        if (state_q == ST_DONE) begin
            bank_valid_d[active_q] = 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            start_q      <= 1'b0;
            bank_ptr_q   <= 1'b0;
            active_q     <= 1'b0;
            nb_q         <= '0;
            nw_q         <= '0;
            bias_cnt_q   <= '0;
            wgt_cnt_q    <= '0;
            O_bias_we    <= 1'b0;
            O_bias_waddr <= '0;
            O_bias_wdata <= '0;
            O_wgt_we     <= 1'b0;
            O_wgt_bank   <= 1'b0;
            O_wgt_waddr  <= '0;
            O_wgt_wdata  <= '0;
            O_bank_valid <= '0;
            O_ap_done    <= 1'b0;
        end else begin
            start_q      <= I_ap_start;
            O_bias_we    <= bias_hit_c;
            O_wgt_we     <= wgt_hit_c;
            O_ap_done    <= (state_d == ST_DONE);
            O_bank_valid <= bank_valid_d;
            if (accept_c) begin
                nb_q       <= words_of(I_in_datab_bytes);
                nw_q       <= words_of(I_in_dataw_bytes);
                bias_cnt_q <= '0;
                wgt_cnt_q  <= '0;
                active_q   <= bank_ptr_q;
            end
            if (bias_hit_c) begin
                O_bias_waddr <= bias_cnt_q[C_BIAS_AW-1:0];
                O_bias_wdata <= I_mem_din;
                bias_cnt_q   <= bias_cnt_q + CNT_W'(1);
            end
            if (wgt_hit_c) begin
                O_wgt_bank  <= active_q;
                O_wgt_waddr <= wgt_cnt_q[C_WGT_AW-1:0];
                O_wgt_wdata <= I_mem_din;
                wgt_cnt_q   <= wgt_cnt_q + CNT_W'(1);
            end
            if (state_q == ST_DONE) begin
                bank_ptr_q <= ~bank_ptr_q;
            end
        end
    end

`ifdef WBL_ERR_CHECK_EN
    logic err_set_c;

    // Any dropped word (any state) or a start edge that was not accepted.
    always_comb begin
        err_set_c = (I_mem_din_valid && !bias_hit_c && !wgt_hit_c)
                    || (start_edge_c && !O_load_ready);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_err <= 1'b0;
        end else if (err_set_c) begin
            O_err <= 1'b1;
        end else if (accept_c) begin
            O_err <= 1'b0;
        end
    end
`else
    assign O_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_bias_loader.sv
// Self-checking bench for weight_bias_loader: table-driven loads, randomized loads against
// a transaction-level model, and hand-written corner sequences (ping-pong, release, reset).
module tb_weight_bias_loader;

    localparam int unsigned DW  = 128;
    localparam int unsigned BAW = 8;
    localparam int unsigned WAW = 10;
`ifdef WBL_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           I_clk = 1'b0;
    logic           I_rst_n;
    logic           I_ap_start;
    logic [31:0]    I_in_datab_bytes;
    logic [31:0]    I_in_dataw_bytes;
    logic [DW-1:0]  I_mem_din;
    logic           I_mem_din_valid;
    logic           I_weight_ch;
    logic           O_bias_we;
    logic [BAW-1:0] O_bias_waddr;
    logic [DW-1:0]  O_bias_wdata;
    logic           O_wgt_we;
    logic           O_wgt_bank;
    logic [WAW-1:0] O_wgt_waddr;
    logic [DW-1:0]  O_wgt_wdata;
    logic [1:0]     I_bank_release;
    logic [1:0]     O_bank_valid;
    logic           O_load_ready;
    logic           O_ap_done;
    logic           O_err;

    weight_bias_loader #(.C_DATA_WIDTH(DW), .C_BIAS_AW(BAW), .C_WGT_AW(WAW)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ap_start(I_ap_start),
        .I_in_datab_bytes(I_in_datab_bytes), .I_in_dataw_bytes(I_in_dataw_bytes),
        .I_mem_din(I_mem_din), .I_mem_din_valid(I_mem_din_valid), .I_weight_ch(I_weight_ch),
        .O_bias_we(O_bias_we), .O_bias_waddr(O_bias_waddr), .O_bias_wdata(O_bias_wdata),
        .O_wgt_we(O_wgt_we), .O_wgt_bank(O_wgt_bank), .O_wgt_waddr(O_wgt_waddr),
        .O_wgt_wdata(O_wgt_wdata), .I_bank_release(I_bank_release),
        .O_bank_valid(O_bank_valid), .O_load_ready(O_load_ready),
        .O_ap_done(O_ap_done), .O_err(O_err)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed { logic [BAW-1:0] addr; logic [DW-1:0] data; } brec_t;
    typedef struct packed { logic bank; logic [WAW-1:0] addr; logic [DW-1:0] data; } wrec_t;
    typedef struct { int bb; int bw; int nb; int nw; } vec_t;

    brec_t bias_q[$];
    wrec_t wgt_q[$];

    int       n_tests = 0;
    int       n_fail  = 0;
    logic [1:0] bank_valid_m = 2'b00;
    logic     ptr_m = 1'b0;
    logic     err_m = 1'b0;

    // Capture every buffer write the DUT issues.
    always @(negedge I_clk) begin
        if (O_bias_we) bias_q.push_back('{O_bias_waddr, O_bias_wdata});
        if (O_wgt_we)  wgt_q.push_back('{O_wgt_bank, O_wgt_waddr, O_wgt_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge I_clk);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_word(input logic ch, input logic [DW-1:0] d);
        I_weight_ch = ch;
        I_mem_din = d;
        I_mem_din_valid = 1'b1;
        tick();
        I_mem_din_valid = 1'b0;
    endtask

    task automatic release_banks(input logic [1:0] mask);
        I_bank_release = mask;
        tick();
        I_bank_release = 2'b00;
        bank_valid_m = bank_valid_m & ~mask;
        chk("rel_bank_valid", O_bank_valid, bank_valid_m);
        chk("rel_load_ready", O_load_ready, !bank_valid_m[ptr_m]);
    endtask

    // One complete load: nb bias and nw weight words in random order with random gaps,
    // optionally one surplus weight word and a release pulse during the done cycle.
    task automatic do_load(input int bb, input int bw, input int nb, input int nw,
                           input bit extra_w, input logic [1:0] rel_done);
        logic [DW-1:0] eb[$];
        logic [DW-1:0] ew[$];
        logic [DW-1:0] d;
        logic bank;
        int sb = 0;
        int sw = 0;
        bias_q.delete();
        wgt_q.delete();
        chk("ready_before_start", O_load_ready, !bank_valid_m[ptr_m]);
        bank = ptr_m;
        I_in_datab_bytes = 32'(bb);
        I_in_dataw_bytes = 32'(bw);
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        err_m = 1'b0;
        chk("ready_in_load", O_load_ready, 0);
        while (sb < nb || sw < nw) begin
            if ($urandom_range(3) == 0) tick();
            d = rand_word();
            if (sw >= nw || (sb < nb && $urandom_range(1) == 0)) begin
                eb.push_back(d);
                sb++;
                send_word(1'b0, d);
            end else begin
                ew.push_back(d);
                sw++;
                send_word(1'b1, d);
            end
        end
        chk("done_not_early", O_ap_done, 0);
        if (extra_w) begin
            I_weight_ch = 1'b1;
            I_mem_din = rand_word();
            I_mem_din_valid = 1'b1;
            err_m = 1'b1;
        end
        tick();
        I_mem_din_valid = 1'b0;
        chk("done_pulse", O_ap_done, 1);
        I_bank_release = rel_done;
        tick();
        I_bank_release = 2'b00;
        bank_valid_m = bank_valid_m & ~rel_done;
        bank_valid_m[bank] = 1'b1;
        ptr_m = ~ptr_m;
        chk("done_single", O_ap_done, 0);
        chk("bank_valid_after", O_bank_valid, bank_valid_m);
        chk("err_after_load", O_err, ERR_EN ? err_m : 1'b0);
        chk("bias_writes", bias_q.size(), nb);
        chk("wgt_writes", wgt_q.size(), nw);
        for (int i = 0; i < bias_q.size() && i < nb; i++) begin
            chk("bias_addr", bias_q[i].addr, i);
            chk("bias_data", bias_q[i].data, eb[i]);
        end
        for (int i = 0; i < wgt_q.size() && i < nw; i++) begin
            chk("wgt_bank", wgt_q[i].bank, bank);
            chk("wgt_addr", wgt_q[i].addr, i);
            chk("wgt_data", wgt_q[i].data, ew[i]);
        end
    endtask

    // Bring the bank pointer back to bank 0 with both banks free.
    task automatic align_ptr0();
        if (ptr_m) begin
            do_load(0, 0, 0, 0, 1'b0, 2'b00);
            release_banks(2'b10);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   bb;
        int   bw;
        vecs[0] = '{64, 256, 4, 16};
        vecs[1] = '{20, 40, 2, 3};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{1, 15, 1, 1};
        vecs[4] = '{16, 17, 1, 2};
        vecs[5] = '{33, 0, 3, 0};
        vecs[6] = '{0, 160, 0, 10};

        I_rst_n = 1'b0;
        I_ap_start = 1'b0;
        I_in_datab_bytes = '0;
        I_in_dataw_bytes = '0;
        I_mem_din = '0;
        I_mem_din_valid = 1'b0;
        I_weight_ch = 1'b0;
        I_bank_release = 2'b00;
        repeat (3) tick();
        chk("rst_bias_we", O_bias_we, 0);
        chk("rst_wgt_we", O_wgt_we, 0);
        chk("rst_bank_valid", O_bank_valid, 0);
        chk("rst_ap_done", O_ap_done, 0);
        I_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", O_load_ready, 1);
        chk("post_rst_err", O_err, 0);
        chk("post_rst_wdata", O_wgt_wdata, 0);

        // Table-driven loads, each bank released right after it completes.
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].bb, vecs[v].bw, vecs[v].nb, vecs[v].nw, 1'b0, 2'b00);
            release_banks(bank_valid_m);
        end

        // Release of bank 0 during its own done cycle: the set must win.
        align_ptr0();
        do_load(16, 16, 1, 1, 1'b0, 2'b01);
        chk("set_wins_release", O_bank_valid[0], 1);
        release_banks(2'b01);

        // Back-to-back loads fill both banks; a third start is ignored.
        align_ptr0();
        do_load(32, 64, 2, 4, 1'b0, 2'b00);
        do_load(5, 48, 1, 3, 1'b0, 2'b00);
        chk("pingpong_valid", O_bank_valid, 2'b11);
        chk("pingpong_not_ready", O_load_ready, 0);
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        err_m = 1'b1;
        chk("ignored_start_err", O_err, ERR_EN ? err_m : 1'b0);
        repeat (2) begin
            tick();
            chk("ignored_start_no_done", O_ap_done, 0);
        end
        chk("ignored_start_ready", O_load_ready, 0);
        release_banks(2'b01);
        release_banks(2'b10);

        // Surplus weight word after the target is reached is dropped.
        do_load(0, 32, 0, 2, 1'b1, 2'b00);
        release_banks(bank_valid_m);

        // Word arriving while idle is dropped.
        bias_q.delete();
        wgt_q.delete();
        send_word(1'b1, rand_word());
        tick();
        err_m = 1'b1;
        chk("idle_drop_writes", wgt_q.size(), 0);
        chk("idle_drop_err", O_err, ERR_EN ? err_m : 1'b0);

        // Randomized loads checked against the word-count rule (ceil(bytes/16)).
        for (int r = 0; r < 6; r++) begin
            bb = $urandom_range(300);
            bw = $urandom_range(300);
            do_load(bb, bw, (bb + 15) / 16, (bw + 15) / 16, 1'b0, 2'b00);
            release_banks(bank_valid_m);
        end

        // Reset in the middle of a load aborts it; next load goes to bank 0.
        align_ptr0();
        do_load(0, 16, 0, 1, 1'b0, 2'b00);
        I_in_datab_bytes = 32'd0;
        I_in_dataw_bytes = 32'd256;
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        repeat (5) send_word(1'b1, rand_word());
        I_rst_n = 1'b0;
        #1;
        chk("midrst_bias_we", O_bias_we, 0);
        chk("midrst_bias_waddr", O_bias_waddr, 0);
        chk("midrst_bias_wdata", O_bias_wdata, 0);
        chk("midrst_wgt_we", O_wgt_we, 0);
        chk("midrst_wgt_bank", O_wgt_bank, 0);
        chk("midrst_wgt_waddr", O_wgt_waddr, 0);
        chk("midrst_wgt_wdata", O_wgt_wdata, 0);
        chk("midrst_bank_valid", O_bank_valid, 0);
        chk("midrst_ap_done", O_ap_done, 0);
        chk("midrst_err", O_err, 0);
        tick();
        I_rst_n = 1'b1;
        bank_valid_m = 2'b00;
        ptr_m = 1'b0;
        err_m = 1'b0;
        repeat (3) begin
            tick();
            chk("midrst_stays_invalid", O_bank_valid, 0);
        end
        chk("midrst_ready", O_load_ready, 1);
        do_load(20, 40, 2, 3, 1'b0, 2'b00);
        chk("midrst_next_bank0", O_bank_valid, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_bias_loader.md
WEIGHT_BIAS_LOADER -- requirements
Module: weight_bias_loader

Interface
REQ-001 Parameters SHALL be: C_DATA_WIDTH, default 128, word width; C_BIAS_AW, default 8, bias buffer address width; C_WGT_AW, default 10, weight bank address width.
REQ-002 I_clk  in  1  sole clock; all logic on rising edge.
REQ-003 I_rst_n  in  1  asynchronous, active-low reset.
REQ-004 I_ap_start  in  1  level start from the controller; its rising edge starts a load.
REQ-005 I_in_datab_bytes  in  32  bias byte count. I_in_dataw_bytes  in  32  weight byte count. Both are sampled on the start edge.
REQ-006 I_mem_din  in  C_DATA_WIDTH  word from the upstream AXI weight reader.
REQ-007 I_mem_din_valid  in  1  word strobe. There is no backpressure.
REQ-008 I_weight_ch  in  1  word class: 0 = bias word, 1 = weight word.
REQ-009 O_bias_we  out  1, O_bias_waddr  out  C_BIAS_AW, O_bias_wdata  out  C_DATA_WIDTH: bias buffer write port.
REQ-010 O_wgt_we  out  1, O_wgt_bank  out  1, O_wgt_waddr  out  C_WGT_AW, O_wgt_wdata  out  C_DATA_WIDTH: ping-pong weight buffer write port.
REQ-011 I_bank_release  in  2  one-cycle pulse per bank from the compute array, meaning "bank consumed".
REQ-012 O_bank_valid  out  2  bank holds a complete weight set.
REQ-013 O_load_ready  out  1  a start will be accepted.
REQ-014 O_ap_done  out  1  one-cycle pulse when the load completes.
REQ-015 O_err  out  1  sticky error flag (see Configuration).

Function
REQ-016 Word counts SHALL be computed as (bytes>>4) + |bytes[3:0]. The bias target is NB and the weight target is NW, both 32-bit.
REQ-017 The FSM SHALL have exactly these states: IDLE, LOAD, DONE.
REQ-018 IDLE→LOAD SHALL occur on the I_ap_start rising edge while O_load_ready=1. On that transition: latch NB and NW, clear both counters, set active bank = bank pointer.
REQ-019 O_load_ready SHALL equal (state==IDLE) && !O_bank_valid[bank pointer].
REQ-020 A start edge while O_load_ready=0 SHALL be ignored, leaving state unchanged.
REQ-021 In LOAD, a valid word with I_weight_ch=0 and bias count<NB SHALL write the bias buffer at address = bias count, then increment the bias count.
REQ-022 In LOAD, a valid word with I_weight_ch=1 and weight count<NW SHALL write the active bank at address = weight count[C_WGT_AW-1:0], then increment the weight count.
REQ-023 Write strobe, address and data SHALL be registered, with exactly 1 cycle latency from I_mem_din_valid.
REQ-024 A valid word whose class counter has already reached its target SHALL be dropped, with no write strobe.
REQ-025 LOAD→DONE SHALL occur the cycle after the weight count reaches NW and the bias count reaches NB.
REQ-026 NW=0 with NB=0 SHALL go LOAD→DONE immediately.
REQ-027 DONE SHALL last one cycle. In DONE: O_ap_done=1, O_bank_valid[active]←1, bank pointer toggles, next state IDLE.
REQ-028 I_bank_release[b] SHALL clear O_bank_valid[b] on the next edge.
REQ-029 A set and a release of the same bank in the same cycle SHALL resolve as set.
REQ-030 Valid words arriving in IDLE or DONE SHALL be dropped.

Reset
REQ-031 Reset SHALL force state=IDLE and bank pointer=0.
REQ-032 Reset SHALL force all counters, all *_we, addresses, data, O_bank_valid, O_ap_done and O_err to 0. O_load_ready SHALL therefore read 1 one cycle after deassertion.
REQ-033 Reset asserted mid-LOAD SHALL abort the load; the partial bank SHALL NOT be marked valid.

Configuration
REQ-034 Macro WBL_ERR_CHECK_EN SHALL control error detection.
REQ-035 With WBL_ERR_CHECK_EN defined: O_err sets on a dropped LOAD-state word, on a word dropped in IDLE/DONE, and on an ignored start edge. O_err clears only on reset or an accepted start.
REQ-036 Without WBL_ERR_CHECK_EN: O_err SHALL be tied 0 and no detection logic SHALL be present. Data-path behaviour SHALL be identical in both builds.

Verification
REQ-037 Scenario: datab=64, dataw=256. Send 4 bias words, then 16 weight words → bias addresses 0..3 and bank 0 addresses 0..15 written, O_ap_done one pulse, O_bank_valid=2'b01.
REQ-038 Scenario: datab=20, dataw=40 (partial words) → NB=2, NW=3, exactly 2+3 writes, done after the 5th word.
REQ-039 Scenario: two back-to-back loads without release → second lands in bank 1, O_bank_valid=2'b11, O_load_ready=0. A third start is ignored (O_err=1 when the macro is on). Pulsing I_bank_release=2'b01 restores ready.
REQ-040 Scenario: 1 extra weight word after NW reached → no O_wgt_we for it, O_err=1 (macro on) or 0 (macro off).
REQ-041 Scenario: I_rst_n low after 5 weight words → all outputs 0, O_bank_valid stays 0, the next start loads into bank 0.
REQ-042 Scenario: I_bank_release[0] in the DONE cycle that sets bank 0 → O_bank_valid[0]=1 afterwards.
